fifo_sync_fwft: RTL
===================

# fifo_sync_fwft

Parametrised synchronous FIFO controller for the FPGA block RAM, succeeding the fixed 15-bit controller. It derives depth and address scaling from the width configuration and keeps an explicit fill counter instead of wrap-bit compares. It adds registered status flags, a fill-level output, sticky error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) mode with an internal 2-entry output stage. It sits between user logic and one single-port-per-side RAM with 1-cycle synchronous read.

## Interface
- ADDR_WIDTH, 15, RAM bit-address width; pointers are ADDR_WIDTH bits.
- DATA_WIDTH, 80, width of ram_rdata_i and dout_o.
- clk_i  in  1  single clock, rising edge.
- a_reset_n_i  in  1  asynchronous, active-low reset.
- fifo_config_i  in  3  width mode: 1=1b, 2=2b, 3=5b, 4=10b, 5=20b, 6=40b, 7 or 0=80b. Static; change only under reset or flush.
- fwft_i  in  1  0=standard, 1=FWFT. Static, same rule as fifo_config_i.
- almost_full_offset_i  in  ADDR_WIDTH  almost-full threshold offset.
- almost_empty_offset_i  in  ADDR_WIDTH  almost-empty threshold offset.
- flush_i  in  1  synchronous clear of all state.
- err_clr_i  in  1  clears the sticky error flags.
- wr_en_i, rd_en_i  in  1  write request; read request (in FWFT: pop).
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid the cycle after re_out_o.
- write_address_o, read_address_o  out  ADDR_WIDTH  RAM bit addresses.
- we_out_o, re_out_o  out  1  RAM write strobe; RAM read strobe.
- dout_o  out  DATA_WIDTH  read data.
- dout_valid_o  out  1  dout_o valid.
- empty_o, full_o, almost_empty_o, almost_full_o  out  1  registered status flags.
- fill_level_o  out  ADDR_WIDTH+1  total words held.
- write_error_o, read_error_o  out  1  sticky overflow / underflow.

## Operation
- Shift s = cfg−1 (s=6 for cfg 0/7). Depth D = 2^(ADDR_WIDTH−s). Pointers wrap at D−1 → 0. Address = ptr[ADDR_WIDTH−s−1:0] followed by s zero bits.
- ram_cnt counts words in RAM (0..D). Write accepted iff wr_en_i && !full_o. we_out_o equals the accepted write; the write pointer increments.
- Standard mode: read accepted iff rd_en_i && !empty_o. re_out_o equals the accepted read. dout_o = ram_rdata_i (pass-through). dout_valid_o is high the cycle after the accept. fill = ram_cnt. empty_o = (ram_cnt==0).
- FWFT mode: sub-module holds head and skid registers (occ 0..2) plus a pending flag for an in-flight fetch.
  - Fetch (re_out_o) when ram_cnt≠0 && occ+pending−pop < 2.
  - Returning data goes to head if head is free after the pop, else to skid.
  - pop = rd_en_i && dout_valid_o. On pop, skid moves to head.
  - dout_valid_o = occ≠0. empty_o = !dout_valid_o. fill = ram_cnt+occ+pending. Capacity is D+2.
- full_o = (ram_cnt==D).
- almost_full_o = ram_cnt ≥ D − almost_full_offset_i, computed in ADDR_WIDTH+2-bit arithmetic; an offset ≥ D forces 1.
- almost_empty_o = fill ≤ almost_empty_offset_i.
- All flags and fill_level_o are registered from next-state counts, so they are correct in the cycle after each event.
- write_error_o sets on wr_en_i && full_o. read_error_o sets on rd_en_i && empty_o. Both stay set until err_clr_i; a set in the same cycle as err_clr_i wins.
- flush_i clears pointers, counts, stage, pending and errors. The RAM is not touched. A fetch in flight during flush is discarded. flush_i has priority over wr_en_i and rd_en_i in the same cycle.

## Timing
- Reset values:
  - All pointers, counts and fill_level_o = 0.
  - empty_o = 1, almost_empty_o = 1.
  - full_o = 0, almost_full_o = 0.
  - dout_o = 0, dout_valid_o = 0.
  - Error flags = 0; we_out_o, re_out_o = 0.
- Reset may assert mid-burst. All state clears immediately and asynchronously.
- Simultaneous write and read on a non-empty, non-full FIFO: ram_cnt is unchanged and both pointers advance.
- A write when full_o=1 is rejected even if a read is accepted in the same cycle. A read when empty_o=1 is rejected even if a write is accepted in the same cycle.
- Standard mode: read accepted in cycle n gives dout_valid_o at n+1.
- FWFT mode, write into an empty FIFO at cycle n:
  - n+1: re_out_o.
  - n+2: RAM data captured.
  - n+3: dout_valid_o=1.
- FWFT sustains one pop per cycle once occ ≥ 1 and ram_cnt > 0.

## Structure
- Package fifo_sync_pkg holds the CONFIG_* constants, the function cfg_shift(cfg) returning s, and the function cfg_depth(cfg, ADDR_WIDTH).
- Sub-module fifo_sync_ostage holds the 2-entry head/skid stage and the pending flag, with ports push, pop, data, occ and valid.

## Test plan
- Reset then idle, cfg=7, ADDR_WIDTH=15 → D=512; empty_o=1, almost_empty_o=1, fill_level_o=0, all strobes 0.
- Standard, cfg=6 (D=1024): 1024 writes → full_o=1 and write_address_o of the last write = 1023<<5. The 1025th write → we_out_o=0, write_error_o=1 until err_clr_i.
- Standard, cfg=7: wrap test; fill to 500, then simultaneous read+write for 100 cycles → fill_level_o stays 500, pointers wrap 511 → 0, data order preserved.
- FWFT, cfg=5: single write at cycle 0 → re_out_o at 1, dout_valid_o at 3. Back-to-back pops of a 10-word burst → dout_valid_o held high for 10 consecutive cycles.
- Thresholds, cfg=4 (D=4096), afo=4, aeo=2: almost_full_o rises in the cycle after the 4092nd word; almost_empty_o falls in the cycle after the 3rd word. An offset of 5000 → almost_full_o=1.
- FWFT with 2 words held plus a pending fetch, then flush_i → the next cycle shows fill_level_o=0, empty_o=1, dout_valid_o=0, and the late RAM data is dropped.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared definitions for the synchronous block-RAM FIFO controller.
// Holds the width-mode encodings and the helpers that turn a width mode
// into an address shift and a word depth.
package fifo_sync_pkg;

  // Width-mode encodings on fifo_config_i (0 aliases the 80-bit mode)
  localparam logic [2:0] CONFIG_80B_ALT = 3'd0;
  localparam logic [2:0] CONFIG_1B      = 3'd1;
  localparam logic [2:0] CONFIG_2B      = 3'd2;
  localparam logic [2:0] CONFIG_5B      = 3'd3;
  localparam logic [2:0] CONFIG_10B     = 3'd4;
  localparam logic [2:0] CONFIG_20B     = 3'd5;
  localparam logic [2:0] CONFIG_40B     = 3'd6;
  localparam logic [2:0] CONFIG_80B     = 3'd7;

  // Output stage holds at most a head and a skid word
  localparam logic [1:0] OCC_MAX = 2'd2;

  // Number of zero bits appended below the word pointer to form a bit address
  function automatic logic [2:0] cfg_shift(input logic [2:0] cfg);
    logic [2:0] s;
    case (cfg)
      CONFIG_1B:  s = 3'd0;
      CONFIG_2B:  s = 3'd1;
      CONFIG_5B:  s = 3'd2;
      CONFIG_10B: s = 3'd3;
      CONFIG_20B: s = 3'd4;
      CONFIG_40B: s = 3'd5;
      default:    s = 3'd6;
    endcase
    return s;
  endfunction

  // Word depth of the RAM for a given width mode
  function automatic int unsigned cfg_depth(input logic [2:0] cfg, input int unsigned aw);
    return 32'd1 << (aw - 32'(cfg_shift(cfg)));
  endfunction

endpackage

// File: rtl/fifo_sync_ostage.sv
// Two-entry output stage used in first-word-fall-through mode.
// A fetch issued to the RAM (push_i) sets the pending flag; its data is
// captured the following cycle into head if head is free after this
// cycle's pop, else into skid. A pop moves skid into head.
// Ports:
//   clk_i, a_reset_n_i : clock, asynchronous active-low reset
//   flush_i            : drop held words and any in-flight fetch
//   push_i             : RAM fetch issued this cycle
//   pop_i              : consumer takes the head word this cycle
//   data_i             : RAM read data (valid the cycle after push_i)
//   data_o             : head word, zero when nothing is held
//   occ_o              : number of words held (0..2)
//   valid_o            : head word valid
//   valid_nxt_o        : head word valid next cycle
//   pending_o          : a fetch is in flight
module fifo_sync_ostage
  import fifo_sync_pkg::*;
#(
  parameter int DATA_WIDTH = 80
) (
  input  logic                  clk_i,
  input  logic                  a_reset_n_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            occ_o,
  output logic                  valid_o,
  output logic                  valid_nxt_o,
  output logic                  pending_o
);

  logic [1:0]            occ_q, occ_d, occ_pop;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] head_q, skid_q;

  always_comb begin
    occ_pop = occ_q - {1'b0, pop_i};
    occ_d   = occ_pop + {1'b0, pend_q};
    pend_d  = push_i;
    if (flush_i) begin
      occ_d  = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge a_reset_n_i) begin
    if (!a_reset_n_i) begin
      occ_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
    end
  end

  // Data words need no reset: occupancy alone decides what is visible
  always_ff @(posedge clk_i) begin
    if (pop_i && occ_q == OCC_MAX) head_q <= skid_q;
    if (pend_q) begin
      if (occ_pop == 2'd0) head_q <= data_i;
      else                 skid_q <= data_i;
    end
  end

  assign valid_o     = (occ_q != 2'd0);
  assign valid_nxt_o = (occ_d != 2'd0);
  assign occ_o       = occ_q;
  assign pending_o   = pend_q;
  assign data_o      = valid_o ? head_q : '0;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Parametrised synchronous FIFO controller for a block RAM with 1-cycle
// synchronous read. Depth and address scaling follow the width mode; an
// explicit word counter drives full/empty. Standard mode passes RAM data
// straight through; FWFT mode prefetches into a 2-entry output stage.
// Ports:
//   clk_i, a_reset_n_i            : clock, asynchronous active-low reset
//   fifo_config_i, fwft_i         : width mode, FWFT select (static)
//   almost_full/empty_offset_i    : threshold offsets
//   flush_i, err_clr_i            : synchronous clear, sticky error clear
//   wr_en_i, rd_en_i              : write request, read/pop request
//   ram_rdata_i                   : RAM read data
//   write/read_address_o          : RAM bit addresses
//   we_out_o, re_out_o            : RAM write/read strobes
//   dout_o, dout_valid_o          : read data and its valid
//   empty/full/almost_*_o         : registered status flags
//   fill_level_o                  : words held in total
//   write_error_o, read_error_o   : sticky overflow / underflow
module fifo_sync_fwft
  import fifo_sync_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 80
) (
  input  logic                  clk_i,
  input  logic                  a_reset_n_i,
  input  logic [2:0]            fifo_config_i,
  input  logic                  fwft_i,
  input  logic [ADDR_WIDTH-1:0] almost_full_offset_i,
  input  logic [ADDR_WIDTH-1:0] almost_empty_offset_i,
  input  logic                  flush_i,
  input  logic                  err_clr_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic [ADDR_WIDTH-1:0] write_address_o,
  output logic [ADDR_WIDTH-1:0] read_address_o,
  output logic                  we_out_o,
  output logic                  re_out_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   fill_level_o,
  output logic                  write_error_o,
  output logic                  read_error_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = ADDR_WIDTH + 2;

  logic [2:0]            shift;
  logic [CW-1:0]         depth;
  logic [TW-1:0]         af_thr;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d, fill_q, fill_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  werr_q, werr_d, rerr_q, rerr_d;
  logic                  std_vld_q, std_vld_d;

  logic                  wr_acc, std_rd, pop, fetch, ram_rd, out_acc;

  logic [DATA_WIDTH-1:0] st_data;
  logic [1:0]            st_occ;
  logic                  st_valid, st_valid_nxt, st_pend;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p,
                                                    input logic [CW-1:0]         d);
    if ({1'b0, p} == d - CW'(1)) return '0;
    return p + ADDR_WIDTH'(1);
  endfunction

  assign shift  = cfg_shift(fifo_config_i);
  assign depth  = CW'(cfg_depth(fifo_config_i, ADDR_WIDTH));
  assign af_thr = {1'b0, depth} - {2'b0, almost_full_offset_i};

  // Flags are registered copies of current counts, so they gate accepts directly
  assign wr_acc = wr_en_i && !full_q && !flush_i;
  assign std_rd = !fwft_i && rd_en_i && !empty_q && !flush_i;
  assign pop    = fwft_i && rd_en_i && st_valid && !flush_i;
  // Prefetch while head+skid+in-flight, after this cycle's pop, leaves a free slot
  assign fetch  = fwft_i && !flush_i && (ram_cnt_q != '0) &&
                  (({1'b0, st_occ} + {2'b0, st_pend}) < (3'd2 + {2'b0, pop}));
  assign ram_rd  = std_rd | fetch;
  assign out_acc = std_rd | pop;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q + CW'(wr_acc) - CW'(ram_rd);
    // Total held only moves on writes and consumer reads; fetches shift words internally
    fill_d    = fill_q + CW'(wr_acc) - CW'(out_acc);
    werr_d    = (wr_en_i && full_q) || (werr_q && !err_clr_i);
    rerr_d    = (rd_en_i && empty_q) || (rerr_q && !err_clr_i);
    std_vld_d = std_rd;
    if (wr_acc) wptr_d = ptr_inc(wptr_q, depth);
    if (ram_rd) rptr_d = ptr_inc(rptr_q, depth);
    if (flush_i) begin
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      fill_d    = '0;
      werr_d    = 1'b0;
      rerr_d    = 1'b0;
      std_vld_d = 1'b0;
    end
    full_d  = (ram_cnt_d == depth);
    empty_d = fwft_i ? !st_valid_nxt : (ram_cnt_d == '0);
    // Offset at or beyond the depth would underflow the threshold: force high
    af_d    = ({2'b0, almost_full_offset_i} >= {1'b0, depth}) ||
              ({1'b0, ram_cnt_d} >= af_thr);
    ae_d    = (fill_d <= {1'b0, almost_empty_offset_i});
  end

  always_ff @(posedge clk_i or negedge a_reset_n_i) begin
    if (!a_reset_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      werr_q    <= 1'b0;
      rerr_q    <= 1'b0;
      std_vld_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      werr_q    <= werr_d;
      rerr_q    <= rerr_d;
      std_vld_q <= std_vld_d;
    end
  end

  fifo_sync_ostage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ostage (
    .clk_i       (clk_i),
    .a_reset_n_i (a_reset_n_i),
    .flush_i     (flush_i),
    .push_i      (fetch),
    .pop_i       (pop),
    .data_i      (ram_rdata_i),
    .data_o      (st_data),
    .occ_o       (st_occ),
    .valid_o     (st_valid),
    .valid_nxt_o (st_valid_nxt),
    .pending_o   (st_pend)
  );

  assign write_address_o = wptr_q << shift;
  assign read_address_o  = rptr_q << shift;
  assign we_out_o        = wr_acc;
  assign re_out_o        = ram_rd;
  assign dout_valid_o    = fwft_i ? st_valid : std_vld_q;
  // Standard mode passes RAM data through, held at zero outside a valid cycle
  assign dout_o          = fwft_i ? st_data : (std_vld_q ? ram_rdata_i : '0);
  assign empty_o         = empty_q;
  assign full_o          = full_q;
  assign almost_empty_o  = ae_q;
  assign almost_full_o   = af_q;
  assign fill_level_o    = fill_q;
  assign write_error_o   = werr_q;
  assign read_error_o    = rerr_q;

endmodule
